// File: rtl/grf_hazard_ctrl_pkg.sv
// Shared types and codes for the GRF hazard/forwarding controller.
// Slot record, forwarding codes and the Tuse "unused" marker.
package grf_hazard_ctrl_pkg;

    localparam int GRF_TW = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam logic [GRF_TW-1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic              v;
        logic [4:0]        a3;
        logic [GRF_TW-1:0] tnew;
    } slot_t;

    function automatic logic [GRF_TW-1:0] tnew_dec(
        input logic [GRF_TW-1:0] t
    );
        return (t == '0) ? '0 : t - GRF_TW'(1);
    endfunction

endpackage

// File: rtl/grf_hazard_ctrl_hazard_match.sv
// Youngest-writer match for one D-stage operand.
// Produces the hazard flag, forwarding code and matched Tnew.
module hazard_match
    import grf_hazard_ctrl_pkg::*;
(
    input  slot_t             SlotE,
    input  slot_t             SlotM,
    input  slot_t             SlotW,
    input  logic [4:0]        Addr,
    input  logic [GRF_TW-1:0] Tuse,
    output logic              Hazard,
    output logic [1:0]        Fwd,
    output logic [GRF_TW-1:0] Tnew
);

    logic  live;
    logic  hit_e;
    logic  hit_m;
    logic  hit_w;
    logic  any;
    slot_t sel;
    logic [1:0] code;

    // $0 is never a real dependency
    assign live  = (Addr != 5'd0);
    assign hit_e = live & SlotE.v & (SlotE.a3 == Addr);
    assign hit_m = live & ~hit_e & SlotM.v & (SlotM.a3 == Addr);
    assign hit_w = live & ~hit_e & ~hit_m
                 & SlotW.v & (SlotW.a3 == Addr);
    assign any   = hit_e | hit_m | hit_w;

    // pick the youngest matching slot (hits are one-hot)
    always_comb begin
        sel  = '0;
        code = FWD_GRF;
        unique case (1'b1)
            hit_e: begin
                sel  = SlotE;
                code = FWD_E;
            end
            hit_m: begin
                sel  = SlotM;
                code = FWD_M;
            end
            hit_w: begin
                sel  = SlotW;
                code = FWD_W;
            end
            default: begin
                sel  = '0;
                code = FWD_GRF;
            end
        endcase
    end

    assign Hazard = any & (Tuse != TUSE_NONE)
                  & (sel.tnew > Tuse);
    assign Fwd    = (any && sel.tnew == '0) ? code : FWD_GRF;
    assign Tnew   = sel.tnew;

endmodule

// File: rtl/grf_hazard_ctrl.sv
// GRF scoreboard: E/M/W writer slots, D-stage stall and forwarding.
// Optional stall trace: define GRF_HAZARD_TRACE_EN.
module grf_hazard_ctrl
    import grf_hazard_ctrl_pkg::*;
#(
    parameter int NSLOT = 3,
    parameter int TW    = GRF_TW
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          D_Valid,
    input  logic [4:0]    D_A1,
    input  logic [4:0]    D_A2,
    input  logic [TW-1:0] D_Tuse1,
    input  logic [TW-1:0] D_Tuse2,
    input  logic          D_WE,
    input  logic [4:0]    D_A3,
    input  logic [TW-1:0] D_Tnew,
    input  logic          Flush,
    output logic          Stall,
    output logic [1:0]    Fwd1,
    output logic [1:0]    Fwd2,
    output logic          W_WE,
    output logic [4:0]    W_A3,
    output logic [31:0]   StallCnt
);

    localparam int SE = 0;
    localparam int SM = 1;
    localparam int SW = 2;

    slot_t slot_q [NSLOT];
    slot_t e_next;
    slot_t m_next;

    logic haz1;
    logic haz2;
    logic [TW-1:0] tnew1;
    logic [TW-1:0] tnew2;
    logic [31:0] cnt_q;

    hazard_match u_match1 (
        .SlotE  (slot_q[SE]),
        .SlotM  (slot_q[SM]),
        .SlotW  (slot_q[SW]),
        .Addr   (D_A1),
        .Tuse   (D_Tuse1),
        .Hazard (haz1),
        .Fwd    (Fwd1),
        .Tnew   (tnew1)
    );

    hazard_match u_match2 (
        .SlotE  (slot_q[SE]),
        .SlotM  (slot_q[SM]),
        .SlotW  (slot_q[SW]),
        .Addr   (D_A2),
        .Tuse   (D_Tuse2),
        .Hazard (haz2),
        .Fwd    (Fwd2),
        .Tnew   (tnew2)
    );

    // flush overrides any hazard
    assign Stall = D_Valid & ~Flush & (haz1 | haz2);

    // next E contents: the D instruction or a bubble
    always_comb begin
        e_next = '0;
        if (D_Valid && !Stall && !Flush) begin
            e_next.v    = D_WE & (D_A3 != 5'd0);
            e_next.a3   = D_A3;
            e_next.tnew = D_Tnew;
        end
    end

    // E moves to M with one cycle of latency consumed
    always_comb begin
        m_next      = slot_q[SE];
        m_next.tnew = tnew_dec(slot_q[SE].tnew);
    end

    // slot shift register and stall counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            slot_q[SW] <= slot_q[SM];
            slot_q[SM] <= m_next;
            slot_q[SE] <= e_next;
            if (Stall) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // the W slot drives the GRF write port directly
    assign W_WE     = slot_q[SW].v;
    assign W_A3     = slot_q[SW].a3;
    assign StallCnt = cnt_q;

`ifdef GRF_HAZARD_TRACE_EN
    // report the first hazardous operand on each stall edge
    always_ff @(posedge Clk) begin
        if (Reset_n && Stall) begin
            if (haz1) begin
                $display("stall $%0d tnew=%0d", D_A1, tnew1);
            end else begin
                $display("stall $%0d tnew=%0d", D_A2, tnew2);
            end
        end
    end
`else
    logic unused_trace;
    assign unused_trace = ^{tnew1, tnew2};
`endif

endmodule

// File: doc/grf_hazard_ctrl.md
Name: grf_hazard_ctrl

Overview:
- Scoreboard/stall controller that sequences access to the 32x32 general register file (GRF) in the 5-stage pipeline (F/D/E/M/W).
- Tracks in-flight GRF writers in E, M and W, and decides per cycle whether the D-stage instruction must stall.
- Selects the source of each D-stage read operand: GRF, E, M or W.
- Drives the GRF write-enable and write-address from its W slot.

Parameters:
- NSLOT, 3, tracked stages after D (E, M, W); fixed at 3, others unsupported.
- TW, 2, width of Tnew/Tuse fields.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- D_Valid  in  1  D stage holds a real instruction.
- D_A1, D_A2  in  5  source register numbers.
- D_Tuse1, D_Tuse2  in  2  cycles after D until the operand is consumed; 3 = operand unused.
- D_WE  in  1  instruction writes the GRF.
- D_A3  in  5  destination register.
- D_Tnew  in  2  cycles after entering E until the result exists (0 = ready in E).
- Flush  in  1  kill the D instruction; a bubble enters E.
- Stall  out  1  freeze F/D this cycle.
- Fwd1, Fwd2  out  2  D operand source: 0 GRF, 1 E, 2 M, 3 W.
- W_WE  out  1  GRF write enable.
- W_A3  out  5  GRF write address.
- StallCnt  out  32  cycles with Stall=1.

Behaviour:
- Slot contents: each of the three slots E, M, W holds {V, A3, Tnew}. V=1 only when the instruction writes a nonzero register.
- Match rule: for operand k, the youngest valid slot (priority E > M > W) with slot.A3==D_Ak. Matching is suppressed when D_Ak==0.
- Hazard_k: match exists, D_Tusek != 3, and slot.Tnew > D_Tusek.
- Stall: combinational, Stall = D_Valid & !Flush & (Hazard1 | Hazard2).
- Fwd_k: combinational.
  - Code of the matching slot when its Tnew==0, otherwise 0.
  - Evaluated even when D_Valid=0.
- Slot advance on rising Clk, every cycle with no hold:
  - W <= M.
  - M <= E, with Tnew decremented, saturating at 0.
  - E <= {D_WE & (D_A3!=0), D_A3, D_Tnew} if D_Valid & !Stall & !Flush; otherwise E <= bubble (V=0).
- Outputs W_WE and W_A3: registered copies of W.V and W.A3, so the GRF write occurs in the W cycle.
- GRF port restriction: the GRF has no internal write-through, so a same-cycle W write must be forwarded with Fwd=3, never read from the GRF.
- StallCnt: increments by 1 at each edge where Stall=1; wraps 0xFFFFFFFF -> 0.
- Reset_n low, asynchronous: all slot V=0, Tnew=0, A3=0, W_WE=0, W_A3=0, StallCnt=0. Stall and Fwd therefore read 0 immediately.
- Reset mid-operation: in-flight writers are discarded and no pending GRF write survives.
- Simultaneous Flush and hazard: Flush wins; Stall=0 and a bubble enters E.
- Both operands hazardous: a single Stall. Stall repeats until both hazards clear.
- Scope: this block provides D-stage forwarding only. E/M-stage operand muxing lies outside it.

Optional Feature:
- GRF_HAZARD_TRACE_EN defined: every edge with Stall=1 prints via $display "stall $<A> tnew=<n>", naming the first hazardous operand.
- GRF_HAZARD_TRACE_EN undefined: no simulation output and no logic difference.

Decomposition:
- Shared package: FWD_GRF/FWD_E/FWD_M/FWD_W codes, TUSE_NONE=3, and the slot record type {V, A3[4:0], Tnew[1:0]}.
- One natural sub-module, hazard_match: combinational youngest-match plus Hazard/Fwd for one operand, instantiated twice.

Test Plan:
- lw $2 (D_Tnew=2) then add reading $2 (Tuse=1) -> Stall=1 for exactly 1 cycle. Next cycle the M slot has Tnew=1: Stall=0, Fwd1=0. StallCnt=1.
- addu $3 (Tnew=1) then beq reading $3 (Tuse=0) -> 1 stall cycle. Then the M match has Tnew=0 -> Fwd1=2. One cycle later Fwd1=3 with W_WE=1, W_A3=3.
- Writer to $0 followed by a reader of $0 -> Stall=0, Fwd=0, W_WE never 1.
- $5 written by instructions now in E (Tnew=0) and M -> Fwd2=1 (youngest wins).
- Flush=1 with D_Valid=1 while a hazard exists -> Stall=0. Three cycles later W_WE=0 for that slot.
- Reset_n low mid-stream with pending lw -> Stall, Fwd, W_WE and StallCnt go to 0 immediately, with no later GRF write.
